// File: rtl/pattern_gen_pkg.sv
// Shared definitions for the animated test pattern generator: pattern codes,
// border geometry and the channel full-scale helper.
package pattern_gen_pkg;

    typedef enum logic [3:0] {
        PAT_BLACK    = 4'd0,
        PAT_RED      = 4'd1,
        PAT_GREEN    = 4'd2,
        PAT_BLUE     = 4'd3,
        PAT_CHECKER  = 4'd4,
        PAT_BARS     = 4'd5,
        PAT_BORDER   = 4'd6,
        PAT_RAMP     = 4'd7,
        PAT_SCROLL   = 4'd8,
        PAT_MOVE_BAR = 4'd9,
        PAT_FLASH    = 4'd10
    } pattern_e;

    // Width of the white frame drawn by the border pattern, in pixels.
    localparam int BORDER_W = 2;

    // Width of the segment counter indices (wide enough for any bar count).
    localparam int SEG_W = 10;

    // All-ones level for a channel of the given width (1..8 bits).
    function automatic logic [7:0] full_level(input int width);
        return 8'((1 << width) - 1);
    endfunction

endpackage

// File: rtl/pattern_gen_anim_seg_counter.sv
// Divider-free segment counter: index advances once every PERIOD advance
// pulses, restarts from zero on clear and saturates at MAX. The registered
// index belongs to the position presented on the previous cycle.
module seg_counter #(
    parameter int PERIOD = 80,
    parameter int MAX    = 7,
    parameter int W      = 10
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] index
);

    localparam int P  = (PERIOD < 1) ? 1 : PERIOD;
    localparam int PW = $clog2(P + 1);

    logic [PW-1:0] phase_reg, phase_next;
    logic [W-1:0]  index_reg, index_next;

    // Next phase/index: clear wins, otherwise step through the segment.
    always_comb begin
        phase_next = phase_reg;
        index_next = index_reg;
        if (clear) begin
            phase_next = '0;
            index_next = '0;
        end else if (advance) begin
            if (phase_reg == PW'(P - 1)) begin
                phase_next = '0;
                if (index_reg != W'(MAX)) begin
                    index_next = index_reg + W'(1);
                end
            end else begin
                phase_next = phase_reg + PW'(1);
            end
        end
    end

    // Counter state register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            phase_reg <= '0;
            index_reg <= '0;
        end else begin
            phase_reg <= phase_next;
            index_reg <= index_next;
        end
    end

    assign index = index_reg;

endmodule

// File: rtl/pattern_gen_anim.sv
// Animated VGA test pattern generator. Stage 1 registers per-pixel geometry
// (active, frame start, scrolled column, bar index, ramp level); stage 2
// selects the pattern and registers RGB. Counts in at n, pixels out at n+2.
module pattern_gen_anim
    import pattern_gen_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int NUM_BARS    = 8,
    parameter int BAR_W       = 16,
    parameter int CHECK_SHIFT = 5,
    parameter int FLASH_SHIFT = 5
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic [3:0]             i_Pattern,
    input  logic [3:0]             i_Step,
    input  logic [9:0]             i_Col_Count,
    input  logic [9:0]             i_Row_Count,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic                   o_Active,
    output logic                   o_Frame_Start
);

    localparam logic [VIDEO_WIDTH-1:0] FULL = VIDEO_WIDTH'(full_level(VIDEO_WIDTH));
    localparam int BAR_PERIOD  = ACTIVE_COLS / NUM_BARS;
    localparam int RAMP_RAW    = ACTIVE_COLS >> VIDEO_WIDTH;
    localparam int RAMP_PERIOD = (RAMP_RAW < 1) ? 1 : RAMP_RAW;

    // Frame-level state, updated only at frame start.
    logic [3:0]  r_Pattern;
    logic [15:0] r_Frame;
    logic [9:0]  r_Offset;

    // Stage 1 registers.
    logic       s1_active_reg;
    logic       s1_fs_reg;
    logic [9:0] s1_xs_reg;
    logic [9:0] s1_col_reg;
    logic [9:0] s1_row_reg;
    logic [SEG_W-1:0] bar_idx;
    logic [SEG_W-1:0] ramp_level;

    logic        fs;
    logic        active_in;
    logic [10:0] offset_sum;
    logic [10:0] offset_wrap;
    logic [9:0]  offset_next;
    logic [10:0] xs_sum;
    logic [10:0] xs_wrap;

    assign fs        = (i_Col_Count == 10'd0) && (i_Row_Count == 10'd0);
    assign active_in = (i_Col_Count < 10'(ACTIVE_COLS)) && (i_Row_Count < 10'(ACTIVE_ROWS));

    // Offset for this pixel: the frame-start pixel already sees the stepped value.
    always_comb begin
        offset_sum  = {1'b0, r_Offset} + {7'd0, i_Step};
        offset_wrap = (offset_sum >= 11'(ACTIVE_COLS)) ? offset_sum - 11'(ACTIVE_COLS) : offset_sum;
        offset_next = fs ? offset_wrap[9:0] : r_Offset;
        xs_sum      = {1'b0, i_Col_Count} + {1'b0, offset_next};
        xs_wrap     = (xs_sum >= 11'(ACTIVE_COLS)) ? xs_sum - 11'(ACTIVE_COLS) : xs_sum;
    end

    // Latch pattern, advance frame count and scroll offset at frame start.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Pattern <= 4'd0;
            r_Frame   <= 16'd0;
            r_Offset  <= 10'd0;
        end else if (fs) begin
            r_Pattern <= i_Pattern;
            r_Frame   <= r_Frame + 16'd1;
            r_Offset  <= offset_next;
        end
    end

    // Stage 1: register geometry of the incoming pixel.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            s1_active_reg <= 1'b0;
            s1_fs_reg     <= 1'b0;
            s1_xs_reg     <= 10'd0;
            s1_col_reg    <= 10'd0;
            s1_row_reg    <= 10'd0;
        end else begin
            s1_active_reg <= active_in;
            s1_fs_reg     <= fs;
            s1_xs_reg     <= xs_wrap[9:0];
            s1_col_reg    <= i_Col_Count;
            s1_row_reg    <= i_Row_Count;
        end
    end

    seg_counter #(
        .PERIOD (BAR_PERIOD),
        .MAX    (NUM_BARS - 1),
        .W      (SEG_W)
    ) u_bar_seg (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .clear   (i_Col_Count == 10'd0),
        .advance (1'b1),
        .index   (bar_idx)
    );

    seg_counter #(
        .PERIOD (RAMP_PERIOD),
        .MAX    ((1 << VIDEO_WIDTH) - 1),
        .W      (SEG_W)
    ) u_ramp_seg (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .clear   (i_Col_Count == 10'd0),
        .advance (1'b1),
        .index   (ramp_level)
    );

    logic [VIDEO_WIDTH-1:0] red_next, grn_next, blu_next;
    logic border_hit, bar_hit;

    // Stage 2 pattern mux; everything outside the active area is black.
    always_comb begin
        red_next   = '0;
        grn_next   = '0;
        blu_next   = '0;
        border_hit = (s1_col_reg < 10'(BORDER_W)) ||
                     (s1_col_reg >= 10'(ACTIVE_COLS - BORDER_W)) ||
                     (s1_row_reg < 10'(BORDER_W)) ||
                     (s1_row_reg >= 10'(ACTIVE_ROWS - BORDER_W));
        bar_hit    = ({1'b0, s1_col_reg} >= {1'b0, r_Offset}) &&
                     ({1'b0, s1_col_reg} < ({1'b0, r_Offset} + 11'(BAR_W)));
        case (r_Pattern)
            PAT_RED:   red_next = FULL;
            PAT_GREEN: grn_next = FULL;
            PAT_BLUE:  blu_next = FULL;
            PAT_CHECKER: begin
                if (s1_col_reg[CHECK_SHIFT] ^ s1_row_reg[CHECK_SHIFT]) begin
                    red_next = FULL;
                    grn_next = FULL;
                    blu_next = FULL;
                end
            end
            PAT_BARS: begin
                red_next = bar_idx[2] ? FULL : '0;
                grn_next = bar_idx[1] ? FULL : '0;
                blu_next = bar_idx[0] ? FULL : '0;
            end
            PAT_BORDER: begin
                if (border_hit) begin
                    red_next = FULL;
                    grn_next = FULL;
                    blu_next = FULL;
                end
            end
            PAT_RAMP: begin
                red_next = ramp_level[VIDEO_WIDTH-1:0];
                grn_next = ramp_level[VIDEO_WIDTH-1:0];
                blu_next = ramp_level[VIDEO_WIDTH-1:0];
            end
            PAT_SCROLL: begin
                if (s1_xs_reg[CHECK_SHIFT] ^ s1_row_reg[CHECK_SHIFT]) begin
                    red_next = FULL;
                    grn_next = FULL;
                    blu_next = FULL;
                end
            end
            PAT_MOVE_BAR: begin
                if (bar_hit) begin
                    red_next = FULL;
                    grn_next = FULL;
                    blu_next = FULL;
                end
            end
            PAT_FLASH: begin
                if (r_Frame[FLASH_SHIFT]) begin
                    red_next = FULL;
                    grn_next = FULL;
                    blu_next = FULL;
                end
            end
            default: ;
        endcase
        if (!s1_active_reg) begin
            red_next = '0;
            grn_next = '0;
            blu_next = '0;
        end
    end

    // Stage 2: register the pixel and its aligned flags.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Red_Video   <= '0;
            o_Grn_Video   <= '0;
            o_Blu_Video   <= '0;
            o_Active      <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_Red_Video   <= red_next;
            o_Grn_Video   <= grn_next;
            o_Blu_Video   <= blu_next;
            o_Active      <= s1_active_reg;
            o_Frame_Start <= s1_fs_reg;
        end
    end

    // Bits of wide helper vectors that the pattern logic does not consume.
    logic unused_bits;
    assign unused_bits = ^{r_Frame, bar_idx, ramp_level, offset_wrap[10], xs_wrap[10]};

endmodule

// File: tb/tb_pattern_gen_anim.sv
// Directed bench for pattern_gen_anim: drives scan lines, captures the
// delayed output per column and checks hand-computed pixels.
module tb_pattern_gen_anim;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic [3:0] i_Pattern = 4'd1;
    logic [3:0] i_Step = 4'd0;
    logic [9:0] i_Col_Count = 10'd0;
    logic [9:0] i_Row_Count = 10'd0;
    logic [2:0] o_Red_Video, o_Grn_Video, o_Blu_Video;
    logic       o_Active, o_Frame_Start;

    int n_cmp = 0;
    int n_err = 0;
    int fs_seen;

    logic [2:0] cap_r [0:800];
    logic [2:0] cap_g [0:800];
    logic [2:0] cap_b [0:800];
    logic       cap_a [0:800];
    logic       cap_fs[0:800];

    pattern_gen_anim dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_Pattern     (i_Pattern),
        .i_Step        (i_Step),
        .i_Col_Count   (i_Col_Count),
        .i_Row_Count   (i_Row_Count),
        .o_Red_Video   (o_Red_Video),
        .o_Grn_Video   (o_Grn_Video),
        .o_Blu_Video   (o_Blu_Video),
        .o_Active      (o_Active),
        .o_Frame_Start (o_Frame_Start)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive cols 0..ncols of one row; cap_*[c] holds the output for column c.
    task automatic line(input int row, input int ncols);
        fs_seen = 0;
        for (int c = 0; c <= ncols; c++) begin
            i_Col_Count = 10'(c);
            i_Row_Count = 10'(row);
            @(posedge i_Clk);
            #1;
            if (c >= 1) begin
                cap_r[c-1]  = o_Red_Video;
                cap_g[c-1]  = o_Grn_Video;
                cap_b[c-1]  = o_Blu_Video;
                cap_a[c-1]  = o_Active;
                cap_fs[c-1] = o_Frame_Start;
                fs_seen += int'(o_Frame_Start);
            end
        end
    endtask

    initial begin
        // Reset with pattern 1 already requested
        repeat (3) @(posedge i_Clk);
        #1;
        check("rst_red", o_Red_Video, 0);
        check("rst_active", o_Active, 0);
        check("rst_fs", o_Frame_Start, 0);
        i_Rst = 1'b0;
        $display("step: reset released");

        // Before any frame start the output stays black
        line(100, 800);
        check("pre_fs_red", cap_r[10], 0);
        check("pre_fs_active", cap_a[10], 1);
        $display("step: line before first frame start");

        // First frame: solid red
        line(0, 800);
        check("red_fs_pulse", cap_fs[0], 1);
        check("red_fs_count", fs_seen, 1);
        check("red_c0_r", cap_r[0], 7);
        check("red_c0_g", cap_g[0], 0);
        check("red_c639_r", cap_r[639], 7);
        check("red_c640_r", cap_r[640], 0);
        check("red_c640_act", cap_a[640], 0);
        line(480, 10);
        check("red_row480_r", cap_r[0], 0);
        check("red_row480_act", cap_a[0], 0);
        $display("step: red frame");

        // Mid-frame switch to green takes effect at the next frame
        i_Pattern = 4'd2;
        line(240, 800);
        check("sw_mid_r", cap_r[5], 7);
        check("sw_mid_g", cap_g[5], 0);
        check("sw_mid_fs", fs_seen, 0);
        line(0, 800);
        check("sw_next_g", cap_g[0], 7);
        check("sw_next_r", cap_r[0], 0);
        check("sw_next_fs", cap_fs[0], 1);
        $display("step: pattern switch");

        // Colour bars
        i_Pattern = 4'd5;
        line(0, 800);
        check("bar_c0_b", cap_b[0], 0);
        check("bar_c79_b", cap_b[79], 0);
        check("bar_c80_b", cap_b[80], 7);
        check("bar_c80_r", cap_r[80], 0);
        check("bar_c159_b", cap_b[159], 7);
        check("bar_c160_g", cap_g[160], 7);
        check("bar_c160_b", cap_b[160], 0);
        check("bar_c560_r", cap_r[560], 7);
        check("bar_c639_g", cap_g[639], 7);
        check("bar_c640_b", cap_b[640], 0);
        $display("step: colour bars");

        // Grey ramp
        i_Pattern = 4'd7;
        line(0, 800);
        check("ramp_c0", cap_r[0], 0);
        check("ramp_c79", cap_g[79], 0);
        check("ramp_c80", cap_b[80], 1);
        check("ramp_c639", cap_r[639], 7);
        check("ramp_c640", cap_r[640], 0);
        $display("step: ramp");

        // Static checker
        i_Pattern = 4'd4;
        line(0, 800);
        check("chk_c31", cap_r[31], 0);
        check("chk_c32", cap_r[32], 7);
        line(32, 40);
        check("chk_r32_c0", cap_g[0], 7);
        $display("step: checker");

        // Border
        i_Pattern = 4'd6;
        line(0, 800);
        check("brd_r0_c100", cap_r[100], 7);
        line(100, 800);
        check("brd_c1", cap_r[1], 7);
        check("brd_c2", cap_r[2], 0);
        check("brd_c637", cap_r[637], 0);
        check("brd_c638", cap_r[638], 7);
        $display("step: border");

        // Moving bar, 4 pixels per frame
        i_Pattern = 4'd9;
        i_Step    = 4'd4;
        line(0, 800);
        check("mb_f1_c3", cap_r[3], 0);
        check("mb_f1_c4", cap_r[4], 7);
        check("mb_f1_c19", cap_r[19], 7);
        check("mb_f1_c20", cap_r[20], 0);
        for (int f = 0; f < 157; f++) line(0, 2);
        line(0, 800);
        check("mb_f159_c635", cap_r[635], 0);
        check("mb_f159_c636", cap_r[636], 7);
        check("mb_f159_c639", cap_r[639], 7);
        check("mb_f159_c640", cap_r[640], 0);
        line(0, 800);
        check("mb_wrap_c0", cap_r[0], 7);
        check("mb_wrap_c15", cap_r[15], 7);
        check("mb_wrap_c16", cap_r[16], 0);
        $display("step: moving bar");

        // Scrolling checker, offset 4
        i_Pattern = 4'd8;
        line(0, 800);
        check("scr_c27", cap_r[27], 0);
        check("scr_c28", cap_r[28], 7);
        check("scr_c635", cap_r[635], 7);
        check("scr_c636", cap_r[636], 0);

        // Asynchronous reset in the middle of a line
        for (int c = 0; c <= 50; c++) begin
            i_Col_Count = 10'(c);
            i_Row_Count = 10'd1;
            @(posedge i_Clk);
            #1;
        end
        check("scr_pre_rst", o_Red_Video, 7);
        #2;
        i_Rst = 1'b1;
        #1;
        check("async_rst_r", o_Red_Video, 0);
        check("async_rst_act", o_Active, 0);
        repeat (3) @(posedge i_Clk);
        #1;
        i_Rst = 1'b0;
        line(100, 800);
        check("post_rst_black", cap_r[270], 0);
        check("post_rst_act", cap_a[270], 1);
        line(0, 800);
        check("post_rst_c27", cap_r[27], 0);
        check("post_rst_c28", cap_r[28], 7);
        $display("step: reset during scroll");

        // Flash: frame counter restarted, white from frame 32
        i_Pattern = 4'd10;
        line(0, 800);
        check("fl_f2_r", cap_r[0], 0);
        check("fl_f2_act", cap_a[0], 1);
        for (int f = 0; f < 29; f++) line(0, 2);
        line(0, 800);
        check("fl_f32_r", cap_r[0], 7);
        check("fl_f32_b", cap_b[639], 7);
        check("fl_f32_g640", cap_g[640], 0);
        i_Pattern = 4'd11;
        line(0, 10);
        check("pat11_black", cap_r[0], 0);
        $display("step: flash and unused code");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_gen_anim.md
# pattern_gen_anim

Parametrised, pipelined successor to the static VGA test pattern generator. It adds a configurable bar count, a gradient ramp, animated patterns (scrolling checkerboard, moving bar, frame flash) and frame-synchronous pattern switching. It sits between the sync/counter block and the video output port. It consumes column/row counts and drives registered RGB with a fixed 2-cycle latency.

## Interface
- VIDEO_WIDTH, 3, bits per colour channel (1..8)
- ACTIVE_COLS, 640, visible columns (>=16)
- ACTIVE_ROWS, 480, visible rows
- NUM_BARS, 8, colour bars across active width (1..ACTIVE_COLS)
- BAR_W, 16, moving-bar width in pixels
- CHECK_SHIFT, 5, checker square size = 2^CHECK_SHIFT
- FLASH_SHIFT, 5, flash toggles every 2^FLASH_SHIFT frames

Ports:
- i_Clk  in  1  pixel clock
- i_Rst  in  1  asynchronous, active-high reset
- i_Pattern  in  4  requested pattern code
- i_Step  in  4  animation pixels per frame (0 = frozen)
- i_Col_Count  in  10  current column from sync block
- i_Row_Count  in  10  current row from sync block
- o_Red_Video / o_Grn_Video / o_Blu_Video  out  VIDEO_WIDTH  pixel colour
- o_Active  out  1  high when the output pixel is in the active area
- o_Frame_Start  out  1  one-cycle pulse aligned with output pixel (0,0)

## Operation
- Frame start (FS): cycle where i_Col_Count==0 and i_Row_Count==0. On FS:
  - latch i_Pattern into r_Pattern
  - r_Frame += 1 (16-bit, wraps)
  - r_Offset = r_Offset + i_Step, minus ACTIVE_COLS if the sum is >= ACTIVE_COLS (single subtract suffices)
- i_Pattern changes between FS events have no effect; every frame renders one pattern.
- Active = col < ACTIVE_COLS && row < ACTIVE_ROWS. Every pattern outputs 0 when not active.
- Pattern codes, with FULL = all ones:
  - 0: black
  - 1: red FULL
  - 2: green FULL
  - 3: blue FULL
  - 4: checker, white where col[CHECK_SHIFT]^row[CHECK_SHIFT]
  - 5: NUM_BARS colour bars; bar index k colours R=k[2], G=k[1], B=k[0]
  - 6: 2-pixel white border
  - 7: horizontal grey ramp, level 0..FULL across active width, all channels equal
  - 8: scrolling checker using xs = (col + r_Offset) wrapped mod ACTIVE_COLS in place of col
  - 9: white vertical bar where r_Offset <= col < r_Offset + BAR_W; no wrap, clipped at the right edge
  - 10: full-screen white when r_Frame[FLASH_SHIFT]==1, else black
  - 11–15: black
- Bar index and ramp level come from segment counters, with no dividers or multipliers:
  - Bars: period ACTIVE_COLS/NUM_BARS (integer). Index clears at col==0, increments on period expiry, saturates at NUM_BARS-1.
  - Ramp: period ACTIVE_COLS>>VIDEO_WIDTH (minimum 1). Level clears at col==0, saturates at FULL.
- Reset (asynchronous, any time): all outputs 0; r_Pattern, r_Frame, r_Offset, segment counters and pipeline registers 0. Output stays black until the first FS after reset release, which then latches i_Pattern.

## Timing
- Stage 1 registers: active flag, FS flag, xs, bar index and ramp level for the incoming counts.
- Stage 2 applies the pattern mux and registers the outputs.
- Latency: counts at cycle n produce o_* at cycle n+2. o_Active and o_Frame_Start are aligned with the video outputs.
- The FS pixel itself is rendered with the newly latched r_Pattern and r_Offset. Stage 1 uses the update value on the FS cycle.
- Counts are assumed to be sequential. A count jump (for example a sync block reset) is tolerated: segment counters resynchronise at the next col==0.

## Structure
- Package pattern_gen_pkg holds:
  - pattern code constants (PAT_BLACK … PAT_FLASH = 10)
  - the 2-pixel border width
  - the FULL helper function
- Sub-module seg_counter (parameters PERIOD, MAX; inputs clear, advance; output index), instantiated once for bars and once for the ramp.

## Test plan
- Reset then i_Pattern=1 from before the first FS: o_* = 0 until FS+2, then red=7, grn=0, blu=0 for active pixels and 0 at col 640..799.
- Pattern 5, defaults: col 0..79 → 0/0/0; col 80 → blue 7; col 560..639 → 7/7/7. Transitions appear exactly 2 cycles after the count crosses.
- Pattern 7, VIDEO_WIDTH=3: col 0 → level 0, col 80 → 1, col 639 → 7, col 640 → 0 (inactive).
- Pattern 9, i_Step=4: frame k shows the bar at col 4k..4k+15; after 160 frames the offset wraps to 0; bar clipped at col 639.
- i_Pattern switched from 1 to 2 at row 240: the remainder of the frame stays red; the next frame is green from pixel (0,0). o_Frame_Start pulses once per frame.
- i_Rst asserted mid-line during pattern 8: outputs are 0 in the same cycle (asynchronous); after release, black until the next FS, with the offset restarting at 0.
